// File: rtl/module_regfile_mp.sv
// rtl/module_regfile_mp.sv - multi-read-port register file with byte-lane writes, write bypass and pending-register scoreboard
module module_regfile_mp #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(NREGS),
  localparam int NBE     = XLEN / 8
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                we_i,
  input  logic [AW-1:0]       wa_i,
  input  logic [XLEN-1:0]     wd_i,
  input  logic [NBE-1:0]      wbe_i,
  input  logic [NRD*AW-1:0]   ra_i,
  output logic [NRD*XLEN-1:0] rd_o,
  input  logic                iss_i,
  input  logic [AW-1:0]       iss_a_i,
  input  logic                flush_i,
  output logic [NRD-1:0]      hazard_o,
  output logic [AW:0]         pend_cnt_o
);

  logic [XLEN-1:0] r_regs [NREGS];
  logic [NREGS-1:0] r_pend;
  logic [AW:0]      r_pend_cnt;

  logic [XLEN-1:0]  w_wr_new;
  logic             w_wr_en;
  logic [NREGS-1:0] w_pend_nxt;
  logic [AW:0]      w_pend_pop;

  // Merged write word doubles as the bypass value for any port reading wa_i.
  always_comb begin
    w_wr_new = r_regs[wa_i];
    for (int b = 0; b < NBE; b++) begin
      if (wbe_i[b]) w_wr_new[b*8 +: 8] = wd_i[b*8 +: 8];
    end
  end

  assign w_wr_en = we_i && !((ZERO_REG != 0) && (wa_i == '0));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (w_wr_en) begin
      r_regs[wa_i] <= w_wr_new;
    end
  end

  // Order matters: clear, then set (set wins), then flush overrides everything.
  always_comb begin
    w_pend_nxt = r_pend;
    if (we_i)    w_pend_nxt[wa_i]    = 1'b0;
    if (iss_i)   w_pend_nxt[iss_a_i] = 1'b1;
    if (flush_i) w_pend_nxt          = '0;
    if (ZERO_REG != 0) w_pend_nxt[0] = 1'b0;
  end

  always_comb begin
    w_pend_pop = '0;
    for (int i = 0; i < NREGS; i++) begin
      w_pend_pop = w_pend_pop + {{AW{1'b0}}, w_pend_nxt[i]};
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_pend     <= '0;
      r_pend_cnt <= '0;
    end else begin
      r_pend     <= w_pend_nxt;
      r_pend_cnt <= w_pend_pop;
    end
  end

  assign pend_cnt_o = r_pend_cnt;

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] w_ra;
    logic          w_zero;
    logic          w_hit;

    assign w_ra   = ra_i[k*AW +: AW];
    assign w_zero = (ZERO_REG != 0) && (w_ra == '0);
    assign w_hit  = (BYPASS != 0) && we_i && (wa_i == w_ra);

    // Bypass is gated by reset so the ports read zero while reset is held.
    assign rd_o[k*XLEN +: XLEN] = (!rst_n_i || w_zero) ? '0 :
                                  (w_hit ? w_wr_new : r_regs[w_ra]);
    assign hazard_o[k] = rst_n_i && !w_zero && r_pend[w_ra] && !w_hit;
  end

endmodule

// File: tb/tb_module_regfile_mp.sv
// tb/tb_module_regfile_mp.sv - directed scoreboard bench for module_regfile_mp (bypass and no-bypass instances)
module tb_module_regfile_mp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic [3:0]  wbe;
  logic [9:0]  ra;
  logic [63:0] rd, rd_nb;
  logic        iss;
  logic [4:0]  iss_a;
  logic        flush;
  logic [1:0]  haz, haz_nb;
  logic [5:0]  cnt, cnt_nb;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t        sb[$];
  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] m_regs [32];

  always #5 clk = ~clk;

  module_regfile_mp dut (
    .clk_i(clk), .rst_n_i(rst_n), .we_i(we), .wa_i(wa), .wd_i(wd), .wbe_i(wbe),
    .ra_i(ra), .rd_o(rd), .iss_i(iss), .iss_a_i(iss_a), .flush_i(flush),
    .hazard_o(haz), .pend_cnt_o(cnt)
  );

  module_regfile_mp #(.BYPASS(0)) dut_nb (
    .clk_i(clk), .rst_n_i(rst_n), .we_i(we), .wa_i(wa), .wd_i(wd), .wbe_i(wbe),
    .ra_i(ra), .rd_o(rd_nb), .iss_i(iss), .iss_a_i(iss_a), .flush_i(flush),
    .hazard_o(haz_nb), .pend_cnt_o(cnt_nb)
  );

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    n_assert++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL sb_underflow: observed %h, no expected value queued", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic drive(input logic w, input logic [4:0] a, input logic [31:0] d,
                       input logic [3:0] be, input logic i, input logic [4:0] ia,
                       input logic f);
    we = w; wa = a; wd = d; wbe = be; iss = i; iss_a = ia; flush = f;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic set_ra(input logic [4:0] a0, input logic [4:0] a1);
    ra = {a1, a0};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] v;
    logic [4:0]  a;
    logic [3:0]  be;

    rst_n = 1'b0;
    idle();
    set_ra(5'd5, 5'd7);
    #3;
    push("reset_rd0", 32'h0);         check(rd[31:0]);
    push("reset_cnt", 32'h0);         check({26'b0, cnt});
    push("reset_haz", 32'h0);         check({30'b0, haz});
    tick();
    rst_n = 1'b1;
    tick();

    // Byte-enable merge
    drive(1'b1, 5'd5, 32'hAABBCCDD, 4'hF, 1'b0, 5'd0, 1'b0); tick();
    drive(1'b1, 5'd5, 32'h11223344, 4'h5, 1'b0, 5'd0, 1'b0); tick();
    idle(); set_ra(5'd5, 5'd5); #2;
    push("be_merge_p0", 32'hAA22CC44); check(rd[31:0]);
    push("be_merge_p1", 32'hAA22CC44); check(rd[63:32]);
    tick();

    // Zero register
    drive(1'b1, 5'd0, 32'hFFFFFFFF, 4'hF, 1'b1, 5'd0, 1'b0); set_ra(5'd0, 5'd0); #2;
    push("x0_bypass_rd", 32'h0);      check(rd[31:0]);
    push("x0_haz", 32'h0);            check({30'b0, haz});
    tick();
    idle(); #2;
    push("x0_rd", 32'h0);             check(rd[31:0]);
    push("x0_cnt", 32'h0);            check({26'b0, cnt});
    tick();

    // Bypass vs no-bypass
    drive(1'b1, 5'd7, 32'h12345678, 4'hF, 1'b0, 5'd0, 1'b0); set_ra(5'd7, 5'd5); #2;
    push("byp_rd0", 32'h12345678);    check(rd[31:0]);
    push("nobyp_rd0_old", 32'h0);     check(rd_nb[31:0]);
    push("byp_rd1_indep", 32'hAA22CC44); check(rd[63:32]);
    tick();
    drive(1'b1, 5'd7, 32'hFFFFFFFF, 4'h3, 1'b0, 5'd0, 1'b0); #2;
    push("byp_partial", 32'h1234FFFF); check(rd[31:0]);
    push("nobyp_partial", 32'h12345678); check(rd_nb[31:0]);
    tick();
    idle(); #2;
    push("nobyp_after", 32'h1234FFFF); check(rd_nb[31:0]);
    tick();

    // Scoreboard issue/clear
    drive(1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 5'd3, 1'b0); tick();
    push("iss3_cnt", 32'd1);          check({26'b0, cnt});
    idle(); set_ra(5'd3, 5'd4); #2;
    push("iss3_haz", 32'b01);         check({30'b0, haz});
    drive(1'b1, 5'd3, 32'hCAFEF00D, 4'hF, 1'b0, 5'd0, 1'b0); #2;
    push("wr3_haz_byp", 32'b00);      check({30'b0, haz});
    push("wr3_haz_nobyp", 32'b01);    check({30'b0, haz_nb});
    tick();
    idle(); #2;
    push("wr3_cnt", 32'd0);           check({26'b0, cnt});
    drive(1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 5'd3, 1'b0); tick();
    drive(1'b1, 5'd3, 32'h0, 4'hF, 1'b1, 5'd3, 1'b0); tick();
    idle(); #2;
    push("setclr_cnt", 32'd1);        check({26'b0, cnt});
    push("setclr_haz", 32'b01);       check({30'b0, haz});
    drive(1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 5'd3, 1'b0); tick();
    push("reiss_cnt", 32'd1);         check({26'b0, cnt});
    drive(1'b1, 5'd4, 32'h0, 4'hF, 1'b0, 5'd0, 1'b0); tick();
    push("clr_nonpend_cnt", 32'd1);   check({26'b0, cnt});
    drive(1'b1, 5'd3, 32'h0, 4'hF, 1'b0, 5'd0, 1'b0); tick();
    push("clr3_cnt", 32'd0);          check({26'b0, cnt});

    // Fill all pending bits then flush
    for (int i = 1; i < 32; i++) begin
      drive(1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 5'(i), 1'b0); tick();
    end
    idle(); set_ra(5'd9, 5'd20); #2;
    push("fill_cnt", 32'd31);         check({26'b0, cnt});
    push("fill_haz", 32'b11);         check({30'b0, haz});
    drive(1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 5'd9, 1'b1); tick();
    idle(); set_ra(5'd9, 5'd31); #2;
    push("flush_cnt", 32'd0);         check({26'b0, cnt});
    push("flush_haz", 32'b00);        check({30'b0, haz});

    // Random byte-lane writes against a reference memory image
    m_regs[0] = 32'h0;
    for (int i = 1; i < 32; i++) begin
      v = $urandom;
      m_regs[i] = v;
      drive(1'b1, 5'(i), v, 4'hF, 1'b0, 5'd0, 1'b0); tick();
    end
    for (int n = 0; n < 24; n++) begin
      a  = 5'($urandom_range(1, 31));
      v  = $urandom;
      be = 4'($urandom_range(0, 15));
      for (int b = 0; b < 4; b++) if (be[b]) m_regs[a][b*8 +: 8] = v[b*8 +: 8];
      drive(1'b1, a, v, be, 1'b0, 5'd0, 1'b0); tick();
    end
    idle();
    for (int i = 1; i < 32; i++) begin
      set_ra(5'(i), 5'(i) ^ 5'h1F); #2;
      push($sformatf("rand_rd0_x%0d", i), m_regs[i]);         check(rd[31:0]);
      push($sformatf("rand_rd1_x%0d", i ^ 31), m_regs[i ^ 31]); check(rd[63:32]);
      tick();
    end

    // Asynchronous reset between edges with a write and issue in flight
    drive(1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 5'd10, 1'b0); tick();
    drive(1'b1, 5'd5, 32'hDEADBEEF, 4'hF, 1'b1, 5'd11, 1'b0); set_ra(5'd5, 5'd10); #2;
    push("pre_rst_byp", 32'hDEADBEEF); check(rd[31:0]);
    push("pre_rst_cnt", 32'd1);       check({26'b0, cnt});
    #1 rst_n = 1'b0;
    #1;
    push("rst_rd0", 32'h0);           check(rd[31:0]);
    push("rst_rd1", 32'h0);           check(rd[63:32]);
    push("rst_haz", 32'h0);           check({30'b0, haz});
    push("rst_cnt", 32'h0);           check({26'b0, cnt});
    push("rst_rd_nb", 32'h0);         check(rd_nb[31:0]);
    tick();
    idle();
    #2 rst_n = 1'b1;
    tick();
    set_ra(5'd5, 5'd11); #2;
    push("post_rst_x5", 32'h0);       check(rd[31:0]);
    push("post_rst_cnt", 32'h0);      check({26'b0, cnt});
    push("post_rst_haz", 32'h0);      check({30'b0, haz});
    drive(1'b1, 5'd5, 32'h01020304, 4'hF, 1'b0, 5'd0, 1'b0); tick();
    idle(); #2;
    push("post_rst_wr", 32'h01020304); check(rd[31:0]);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/module_regfile_mp.md
MODULE_REGFILE_MP -- requirements
Module: module_regfile_mp

Interface
REQ-001 SHALL have parameter XLEN, default 32: register width in bits; multiple of 8.
REQ-002 SHALL have parameter NREGS, default 32: register count; power of 2, ≥2; AW = log2(NREGS).
REQ-003 SHALL have parameter NRD, default 2: number of read ports, 1..4.
REQ-004 SHALL have parameter ZERO_REG, default 1: 1 = register 0 hardwired to zero.
REQ-005 SHALL have parameter BYPASS, default 1: 1 = same-cycle write-to-read forwarding.
REQ-006 SHALL have port clk_i, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-007 SHALL have port rst_n_i, input, 1 bit: reset, asynchronous and active-low.
REQ-008 SHALL have port we_i, input, 1 bit: write enable.
REQ-009 SHALL have port wa_i, input, AW bits: write address.
REQ-010 SHALL have port wd_i, input, XLEN bits: write data.
REQ-011 SHALL have port wbe_i, input, XLEN/8 bits: byte enables for the write.
REQ-012 SHALL have port ra_i, input, NRD×AW bits: read addresses; port k occupies bits [k*AW +: AW].
REQ-013 SHALL have port rd_o, output, NRD×XLEN bits: read data, packed the same way as ra_i.
REQ-014 SHALL have port iss_i, input, 1 bit: issue strobe; marks register iss_a_i as pending.
REQ-015 SHALL have port iss_a_i, input, AW bits: destination register of the issue.
REQ-016 SHALL have port flush_i, input, 1 bit: clears all pending bits.
REQ-017 SHALL have port hazard_o, output, NRD bits: per-read-port "operand not yet valid".
REQ-018 SHALL have port pend_cnt_o, output, AW+1 bits: count of pending registers.

Function
REQ-019 Reads SHALL be combinational, with zero-cycle latency from ra_i to rd_o.
REQ-020 Writes SHALL occur on the rising clock edge when we_i=1; only byte lanes with wbe_i[b]=1 are updated, all other lanes keep their value.
REQ-021 With ZERO_REG=1, writes to address 0 SHALL be discarded, reads of address 0 SHALL return 0, and pending bit 0 SHALL never be set.
REQ-022 With BYPASS=1, when we_i=1 and wa_i equals ra_k, rd_o[k] SHALL return the stored value merged with wd_i on the enabled lanes; address 0 with ZERO_REG=1 still returns 0.
REQ-023 With BYPASS=0, rd_o SHALL return the pre-write stored value in the write cycle.
REQ-024 The block SHALL hold a pending bitvector of NREGS bits; at each edge, we_i=1 clears pend[wa_i] and iss_i=1 sets pend[iss_a_i].
REQ-025 When set and clear target the same register in the same cycle, set SHALL win and the bit ends at 1.
REQ-026 flush_i=1 SHALL clear every pending bit and override iss_i in the same cycle; register contents and the write in that cycle are unaffected.
REQ-027 hazard_o[k] SHALL equal pend[ra_k] AND NOT (BYPASS AND we_i AND wa_i==ra_k); hazard_o[k] is always 0 for address 0 when ZERO_REG=1.
REQ-028 pend_cnt_o SHALL be a registered population count of the pending vector, valid in the cycle after the bit change; it ranges 0..NREGS and cannot wrap.
REQ-029 Issuing to an already-pending register SHALL leave the count unchanged; clearing a non-pending register SHALL leave the count unchanged.
REQ-030 Multiple read ports SHALL be fully independent, and identical addresses on different ports SHALL return identical data.

Reset
REQ-031 While rst_n_i=0, every register SHALL be 0, every pending bit SHALL be 0, and pend_cnt_o SHALL be 0, asynchronously and regardless of clk_i.
REQ-032 Reset asserted mid-operation SHALL discard any write or issue in flight; the first edge after deassertion behaves normally.
REQ-033 During reset, rd_o SHALL read 0 on every port and hazard_o SHALL be all zero.

Verification
REQ-034 Byte-enable merge: write x5=0xAABBCCDD with wbe=1111, then wd=0x11223344 with wbe=0101 -> x5 reads 0xAA22CC44.
REQ-035 Zero register: write x0=0xFFFFFFFF and issue x0 -> rd of x0 is 0, hazard is 0, pend_cnt_o is 0.
REQ-036 Bypass: in one cycle write x7=0x12345678 and read ra0=x7 -> rd_o[0]=0x12345678 in the same cycle; with BYPASS=0 it shows the old value.
REQ-037 Scoreboard: issue x3, then read x3 -> hazard 1 and pend_cnt 1; write x3 -> hazard 0 in the write cycle and pend_cnt 0 the next cycle; set and clear of x3 in the same cycle -> pending stays 1.
REQ-038 Flush and count: issue x1..x31 over 31 cycles -> pend_cnt 31; flush together with issue of x9 -> pend_cnt 0 and no hazards.
REQ-039 Async reset: assert rst_n_i between clock edges after loading data -> all outputs read 0 immediately with no clock edge.
